// File: rtl/reg_dump_reader.sv
// Reads NUM_REGISTERS words from a register file and streams them out as bytes, LSB first.
// Optional feature: define REG_DUMP_CHECKSUM_EN to append an XOR checksum byte after the last register.
module reg_dump_reader #(
  parameter int WIDTH         = 32,
  parameter int WIDTH_ADD     = 5,
  parameter int NUM_REGISTERS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [WIDTH_ADD-1:0] rd_addr,
  input  logic [WIDTH-1:0]     rd_data,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 done
);

  localparam int BYTES = WIDTH / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0]     LAST_BYTE = CNT_W'(BYTES - 1);
  localparam logic [WIDTH_ADD-1:0] LAST_ADDR = WIDTH_ADD'(NUM_REGISTERS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    FINISH
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shift;
  logic [CNT_W-1:0] byte_cnt;
  logic             last_byte;

`ifdef REG_DUMP_CHECKSUM_EN
  logic [7:0] csum;
  logic       csum_phase;
`endif

  // The byte on the wire is always the low byte of the shift register; the checksum is loaded there too.
  assign tx_data   = shift[7:0];
  assign last_byte = (byte_cnt == LAST_BYTE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rd_addr  <= '0;
      shift    <= '0;
      byte_cnt <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum       <= '0;
      csum_phase <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD;
            rd_addr <= '0;
            busy    <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
            csum       <= '0;
            csum_phase <= 1'b0;
`endif
          end
        end

        LOAD: begin
          shift    <= rd_data;
          byte_cnt <= '0;
          tx_valid <= 1'b1;
          state    <= SEND;
        end

        // Nothing moves unless the transmitter takes the byte, so a stall holds data and state.
        SEND: begin
          if (tx_ready) begin
            shift    <= shift >> 8;
            byte_cnt <= byte_cnt + CNT_W'(1);
`ifdef REG_DUMP_CHECKSUM_EN
            if (csum_phase) begin
              csum_phase <= 1'b0;
              tx_valid   <= 1'b0;
              done       <= 1'b1;
              state      <= FINISH;
            end else begin
              csum <= csum ^ shift[7:0];
              if (last_byte) begin
                if (rd_addr < LAST_ADDR) begin
                  rd_addr  <= rd_addr + WIDTH_ADD'(1);
                  tx_valid <= 1'b0;
                  state    <= LOAD;
                end else begin
                  csum_phase <= 1'b1;
                  shift      <= WIDTH'(csum ^ shift[7:0]);
                end
              end
            end
`else
            if (last_byte) begin
              if (rd_addr < LAST_ADDR) begin
                rd_addr  <= rd_addr + WIDTH_ADD'(1);
                tx_valid <= 1'b0;
                state    <= LOAD;
              end else begin
                tx_valid <= 1'b0;
                done     <= 1'b1;
                state    <= FINISH;
              end
            end
`endif
          end
        end

        FINISH: begin
          state   <= IDLE;
          rd_addr <= '0;
          busy    <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          tx_valid <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed self-checking bench for reg_dump_reader at default parameters.
// Checksum expectations are enabled when REG_DUMP_CHECKSUM_EN is defined for the build.
module tb_reg_dump_reader;

`ifdef REG_DUMP_CHECKSUM_EN
  localparam int EXP_BYTES = 129;
  localparam int EXP_BUSY  = 162;
`else
  localparam int EXP_BYTES = 128;
  localparam int EXP_BUSY  = 161;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  logic [31:0] regs [32];
  logic [7:0]  bytes_q [$];
  int          checks = 0;
  int          errors = 0;
  int          done_count;
  int          busy_cycles;
  int          hold_violations;
  int          first_valid_cyc;
  logic [15:0] lfsr = 16'hACE1;

  always #5 clk = ~clk;

  assign rd_data = regs[rd_addr];

  reg_dump_reader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int k);
    logic [31:0] w;
    w = regs[k / 4];
    return w[8 * (k % 4) +: 8];
  endfunction

  // Compares the captured byte stream against the register model (plus checksum when enabled).
  task automatic check_stream(input string tag);
    int         mism = 0;
    logic [7:0] x = 8'h00;
    checkOutput({tag, "_count"}, bytes_q.size(), EXP_BYTES);
    for (int k = 0; k < 128; k++) begin
      x ^= exp_byte(k);
      if (k >= bytes_q.size() || bytes_q[k] !== exp_byte(k)) mism++;
    end
    checkOutput({tag, "_data"}, mism, 0);
`ifdef REG_DUMP_CHECKSUM_EN
    checkOutput({tag, "_csum"}, (bytes_q.size() > 128) ? {24'h0, bytes_q[128]} : 32'hBAD0_0000, {24'h0, x});
`endif
  endtask

  // Runs one dump from a start pulse; mode 1 throttles tx_ready pseudo-randomly.
  task automatic applyStimulus(input int mode, input int restart_at, input int abort_at, input bit start_in_finish);
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    bit         finished = 1'b0;
    bytes_q.delete();
    done_count      = 0;
    busy_cycles     = 0;
    hold_violations = 0;
    first_valid_cyc = -1;
    @(negedge clk);
    start    = 1'b1;
    tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (busy) busy_cycles++;
      if (done) done_count++;
      if (tx_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_stall && tx_valid && tx_data !== prev_data) hold_violations++;
      if (done_count > 0 && !busy) begin
        finished = 1'b1;
        break;
      end
      if (abort_at >= 0 && tx_valid && bytes_q.size() == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_tx_valid", tx_valid, 0);
        checkOutput("abort_rd_addr", rd_addr, 0);
        finished = 1'b1;
        break;
      end
      if (mode == 1) begin
        lfsr     = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        tx_ready = lfsr[0];
      end else begin
        tx_ready = 1'b1;
      end
      start = (cyc == restart_at) || (start_in_finish && done);
      if (tx_valid && tx_ready) bytes_q.push_back(tx_data);
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      @(negedge clk);
    end
    start    = 1'b0;
    tx_ready = 1'b1;
    checkOutput("dump_terminated", finished, 1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    tx_ready = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h0101_0101 * i;

    repeat (2) @(negedge clk);
    checkOutput("reset_rd_addr", rd_addr, 0);
    checkOutput("reset_tx_data", tx_data, 0);
    checkOutput("reset_tx_valid", tx_valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    reset = 1'b0;

    $display("[TB] full-speed dump");
    applyStimulus(0, -1, -1, 1'b0);
    check_stream("basic");
    checkOutput("basic_byte4", bytes_q[4], 8'h01);
    checkOutput("basic_byte7", bytes_q[7], 8'h01);
    checkOutput("basic_byte127", bytes_q[127], 8'h1F);
    checkOutput("basic_done_pulses", done_count, 1);
    checkOutput("basic_busy_cycles", busy_cycles, EXP_BUSY);
    checkOutput("basic_first_valid", first_valid_cyc, 1);

    $display("[TB] throttled dump");
    regs[1] = 32'hDEAD_BEEF;
    applyStimulus(1, -1, -1, 1'b0);
    check_stream("throttle");
    checkOutput("throttle_r1_b0", bytes_q[4], 8'hEF);
    checkOutput("throttle_r1_b1", bytes_q[5], 8'hBE);
    checkOutput("throttle_r1_b2", bytes_q[6], 8'hAD);
    checkOutput("throttle_r1_b3", bytes_q[7], 8'hDE);
    checkOutput("throttle_hold", hold_violations, 0);
    checkOutput("throttle_done_pulses", done_count, 1);

    $display("[TB] start while busy");
    applyStimulus(0, 50, -1, 1'b0);
    check_stream("restart");
    checkOutput("restart_done_pulses", done_count, 1);
    checkOutput("restart_busy_cycles", busy_cycles, EXP_BUSY);

    $display("[TB] reset mid-dump");
    applyStimulus(0, -1, 30, 1'b0);
    applyStimulus(0, -1, -1, 1'b0);
    check_stream("after_abort");
    checkOutput("after_abort_first", bytes_q[0], 8'h00);

    $display("[TB] start during FINISH");
    applyStimulus(0, -1, -1, 1'b1);
    @(negedge clk);
    checkOutput("finish_start_busy", busy, 0);
    checkOutput("finish_start_valid", tx_valid, 0);

    $display("[TB] reset and start together");
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    checkOutput("rst_start_busy", busy, 0);
    checkOutput("rst_start_valid", tx_valid, 0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checkOutput("rst_start_idle", busy, 0);

`ifdef REG_DUMP_CHECKSUM_EN
    $display("[TB] checksum of all-ones registers");
    for (int i = 0; i < 32; i++) regs[i] = 32'hFFFF_FFFF;
    applyStimulus(0, -1, -1, 1'b0);
    check_stream("csum_ones");
    checkOutput("csum_ones_last", bytes_q[128], 8'h00);

    $display("[TB] checksum of single byte");
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    regs[0] = 32'h0000_00A5;
    applyStimulus(1, -1, -1, 1'b0);
    check_stream("csum_a5");
    checkOutput("csum_a5_last", bytes_q[128], 8'hA5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
